// File: rtl/dl_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dl_seq_ctrl
// Sequences a ROM image download into a game core: forwards in-range download
// bytes to the ROM write port, tracks byte count and a modulo-256 checksum,
// flags bad images, holds the core in reset while loading plus a short settle
// time, then releases it.
//
// Ports
//   clk_sys        : single clock
//   Reset_n        : synchronous active-low reset
//   ioctl_download : download window active
//   ioctl_wr       : download byte strobe
//   ioctl_addr     : download byte address (25 bits)
//   ioctl_dout     : download byte data
//   dn_addr        : ROM write address (registered)
//   dn_data        : ROM write data (registered)
//   dn_wr          : ROM write strobe, one-cycle pulse per accepted byte
//   core_reset_n   : reset to the game core, 0 = hold (registered)
//   dl_done        : valid image loaded and core running (registered)
//   dl_err         : sticky error for the current image
//   byte_count     : accepted bytes in the current download (saturating)
//   checksum       : modulo-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module dl_seq_ctrl #(
  parameter logic [16:0] ROM_BYTES   = 17'h0C000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        Reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset_n,
  output logic        dl_done,
  output logic        dl_err,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        dl_prev_q, dl_prev_d;
  logic        arm_q, arm_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [16:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;
  logic        core_reset_n_q, core_reset_n_d;
  logic        dl_done_q, dl_done_d;
  logic        dl_err_q, dl_err_d;
  logic [16:0] byte_count_q, byte_count_d;
  logic [7:0]  checksum_q, checksum_d;

  logic        start_edge, end_edge;
  logic        wr_accept, addr_ok, wr_good, wr_bad;
  logic [16:0] count_base;
  logic [7:0]  sum_base;
  logic        err_base;

  // Edge detection and write qualification.
  // The prev-download register is zeroed by reset, so a download still high
  // after reset would look like a fresh start edge. arm_q blocks start edges
  // until ioctl_download has been seen low once since reset.
  always_comb begin
    start_edge = ioctl_download & ~dl_prev_q & arm_q;
    end_edge   = ~ioctl_download & dl_prev_q;
    wr_accept  = ioctl_wr & ioctl_download & ((state_q == S_LOAD) | start_edge);
    addr_ok    = (ioctl_addr < {8'd0, ROM_BYTES});
    wr_good    = wr_accept & addr_ok;
    wr_bad     = wr_accept & ~addr_ok;
    dl_prev_d  = ioctl_download;
    arm_d      = arm_q | ~ioctl_download;
  end

  // Next state and HOLD counter
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_BOOT: begin
        if (start_edge) state_d = S_LOAD;
        else            state_d = S_BOOT;
      end
      S_LOAD: begin
        if (end_edge) begin
          state_d    = S_HOLD;
          hold_cnt_d = 8'd0;
        end else begin
          state_d    = S_LOAD;
        end
      end
      S_HOLD: begin
        // A reload request beats the terminal count.
        if (start_edge) begin
          state_d = S_LOAD;
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (dl_err_q) state_d = S_BOOT;
          else          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (start_edge) state_d = S_LOAD;
        else            state_d = S_RUN;
      end
      default: begin
        state_d    = S_BOOT;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // Datapath: ROM write port, byte count, checksum, error flag, core controls.
  // A start edge clears the per-image state and any write in the same cycle
  // is applied on top of the cleared values.
  always_comb begin
    count_base = start_edge ? 17'd0 : byte_count_q;
    sum_base   = start_edge ? 8'd0  : checksum_q;
    err_base   = start_edge ? 1'b0  : dl_err_q;

    if (wr_good) begin
      if (count_base != 17'h1FFFF) byte_count_d = count_base + 17'd1;
      else                         byte_count_d = count_base;
      checksum_d = sum_base + ioctl_dout;
      dn_addr_d  = ioctl_addr[16:0];
      dn_data_d  = ioctl_dout;
    end else begin
      byte_count_d = count_base;
      checksum_d   = sum_base;
      dn_addr_d    = dn_addr_q;
      dn_data_d    = dn_data_q;
    end
    dn_wr_d = wr_good;

    dl_err_d = err_base | wr_bad |
               (end_edge & (state_q == S_LOAD) & (byte_count_q != ROM_BYTES));

    // Decoded from the next state so the registered outputs change in the
    // first cycle of the new state and never glitch.
    core_reset_n_d = (state_d == S_RUN);
    dl_done_d      = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      state_q        <= S_BOOT;
      dl_prev_q      <= 1'b0;
      arm_q          <= 1'b0;
      hold_cnt_q     <= 8'd0;
      dn_addr_q      <= 17'd0;
      dn_data_q      <= 8'd0;
      dn_wr_q        <= 1'b0;
      core_reset_n_q <= 1'b0;
      dl_done_q      <= 1'b0;
      dl_err_q       <= 1'b0;
      byte_count_q   <= 17'd0;
      checksum_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      dl_prev_q      <= dl_prev_d;
      arm_q          <= arm_d;
      hold_cnt_q     <= hold_cnt_d;
      dn_addr_q      <= dn_addr_d;
      dn_data_q      <= dn_data_d;
      dn_wr_q        <= dn_wr_d;
      core_reset_n_q <= core_reset_n_d;
      dl_done_q      <= dl_done_d;
      dl_err_q       <= dl_err_d;
      byte_count_q   <= byte_count_d;
      checksum_q     <= checksum_d;
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign core_reset_n = core_reset_n_q;
  assign dl_done      = dl_done_q;
  assign dl_err       = dl_err_q;
  assign byte_count   = byte_count_q;
  assign checksum     = checksum_q;

endmodule

// File: tb/tb_dl_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dl_seq_ctrl
// Directed bench for dl_seq_ctrl: nominal 48 KiB load, reload from RUN, short
// image with a write on the falling download and a stray idle write,
// out-of-range writes, and a reset in the middle of a load.
// Inputs change 1 time unit after a rising edge; outputs are read there too,
// so each read reflects the inputs applied before that edge.
// -----------------------------------------------------------------------------
module tb_dl_seq_ctrl;

  logic        clk_sys = 1'b0;
  logic        Reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset_n;
  logic        dl_done;
  logic        dl_err;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  int n_cmp = 0;
  int n_mis = 0;

  dl_seq_ctrl dut (
    .clk_sys        (clk_sys),
    .Reset_n        (Reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset_n   (core_reset_n),
    .dl_done        (dl_done),
    .dl_err         (dl_err),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".dn_wr"},        32'(dn_wr),        32'd0);
    check({tag, ".dn_addr"},      32'(dn_addr),      32'd0);
    check({tag, ".dn_data"},      32'(dn_data),      32'd0);
    check({tag, ".core_reset_n"}, 32'(core_reset_n), 32'd0);
    check({tag, ".dl_done"},      32'(dl_done),      32'd0);
    check({tag, ".dl_err"},       32'(dl_err),       32'd0);
    check({tag, ".byte_count"},   32'(byte_count),   32'd0);
    check({tag, ".checksum"},     32'(checksum),     32'd0);
  endtask

  initial begin
    // ---- reset ----
    Reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    repeat (3) tick();
    check_reset_vals("reset");
    Reset_n = 1'b1;
    repeat (2) tick();
    check("boot_core_reset_n", 32'(core_reset_n), 32'd0);

    // ---- nominal load: 49152 bytes, data = addr[7:0] ----
    ioctl_download = 1'b1;
    for (int i = 0; i < 49152; i++) begin
      if (i == 1000) begin
        ioctl_wr = 1'b0;
        tick();
        check("nom_gap_dn_wr", 32'(dn_wr), 32'd0);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = i[7:0];
      tick();
      check("nom_dn", {6'd0, dn_wr, dn_addr, dn_data}, {6'd0, 1'b1, 17'(i), i[7:0]});
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();                                  // first HOLD cycle
    check("nom_dn_wr_end",   32'(dn_wr),        32'd0);
    check("nom_byte_count",  32'(byte_count),   32'h0C000);
    check("nom_checksum",    32'(checksum),     32'h00);
    check("nom_dl_err",      32'(dl_err),       32'd0);
    check("nom_hold_reset",  32'(core_reset_n), 32'd0);
    repeat (15) tick();
    check("nom_hold_last",   32'(core_reset_n), 32'd0);
    tick();                                  // 16 cycles after first HOLD cycle
    check("nom_run_reset_n", 32'(core_reset_n), 32'd1);
    check("nom_run_done",    32'(dl_done),      32'd1);
    repeat (3) tick();
    check("nom_run_stay",    32'(dl_done),      32'd1);

    // ---- reload from RUN ----
    ioctl_download = 1'b1;
    tick();
    check("reload_core_reset_n", 32'(core_reset_n), 32'd0);
    check("reload_dl_done",      32'(dl_done),      32'd0);
    check("reload_byte_count",   32'(byte_count),   32'd0);
    check("reload_checksum",     32'(checksum),     32'd0);
    check("reload_dl_err",       32'(dl_err),       32'd0);

    // ---- short image: 100 bytes, data = i+1, sum 5050 mod 256 = 0xBA ----
    for (int i = 0; i < 100; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i + 1);
      tick();
      check("short_dn_wr", 32'(dn_wr), 32'd1);
    end
    // write coinciding with the falling download
    ioctl_addr     = 25'd100;
    ioctl_dout     = 8'h55;
    ioctl_download = 1'b0;
    tick();                                  // first HOLD cycle
    check("fall_dn_wr",      32'(dn_wr),      32'd0);
    check("fall_byte_count", 32'(byte_count), 32'd100);
    check("fall_checksum",   32'(checksum),   32'hBA);
    check("short_dl_err",    32'(dl_err),     32'd1);
    check("short_dl_done",   32'(dl_done),    32'd0);
    // stray write while idle
    ioctl_addr = 25'd5;
    ioctl_dout = 8'h33;
    tick();
    check("stray_dn_wr",      32'(dn_wr),      32'd0);
    check("stray_byte_count", 32'(byte_count), 32'd100);
    check("stray_checksum",   32'(checksum),   32'hBA);
    ioctl_wr = 1'b0;
    repeat (15) tick();                      // past terminal count -> BOOT
    check("short_after_hold_reset_n", 32'(core_reset_n), 32'd0);
    check("short_after_hold_done",    32'(dl_done),      32'd0);
    repeat (3) tick();
    check("short_boot_reset_n", 32'(core_reset_n), 32'd0);

    // ---- out-of-range writes ----
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'h10;
    tick();
    check("oor_first_dn", {6'd0, dn_wr, dn_addr, dn_data}, {6'd0, 1'b1, 17'd0, 8'h10});
    check("oor_first_cnt", 32'(byte_count), 32'd1);
    check("oor_first_err", 32'(dl_err),     32'd0);
    ioctl_addr = 25'h000C000;
    ioctl_dout = 8'h77;
    tick();
    check("oor_limit_dn_wr", 32'(dn_wr),      32'd0);
    check("oor_limit_cnt",   32'(byte_count), 32'd1);
    check("oor_limit_sum",   32'(checksum),   32'h10);
    check("oor_limit_err",   32'(dl_err),     32'd1);
    ioctl_addr = 25'h0200005;
    ioctl_dout = 8'h99;
    tick();
    check("oor_high_dn_wr",  32'(dn_wr),      32'd0);
    check("oor_high_cnt",    32'(byte_count), 32'd1);
    ioctl_addr = 25'd1;
    ioctl_dout = 8'h05;
    tick();
    check("oor_next_dn", {6'd0, dn_wr, dn_addr, dn_data}, {6'd0, 1'b1, 17'd1, 8'h05});
    check("oor_next_cnt", 32'(byte_count), 32'd2);
    check("oor_next_sum", 32'(checksum),   32'h15);
    check("oor_next_err", 32'(dl_err),     32'd1);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();                                  // first HOLD cycle
    repeat (16) tick();
    check("oor_boot_reset_n", 32'(core_reset_n), 32'd0);
    check("oor_boot_done",    32'(dl_done),      32'd0);

    // ---- reset at byte 500 with download held high ----
    ioctl_download = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = i[7:0];
      tick();
    end
    check("mid_cnt_before", 32'(byte_count), 32'd500);
    Reset_n    = 1'b0;
    ioctl_addr = 25'd500;
    ioctl_dout = 8'hF4;
    tick();
    check_reset_vals("mid_reset");
    Reset_n = 1'b1;
    for (int i = 501; i < 506; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = i[7:0];
      tick();
      check("mid_after_dn_wr", 32'(dn_wr),      32'd0);
      check("mid_after_cnt",   32'(byte_count), 32'd0);
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) tick();
    check("mid_low_err",     32'(dl_err),       32'd0);
    check("mid_low_reset_n", 32'(core_reset_n), 32'd0);
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'hAB;
    tick();
    check("mid_restart_dn", {6'd0, dn_wr, dn_addr, dn_data}, {6'd0, 1'b1, 17'd0, 8'hAB});
    check("mid_restart_cnt", 32'(byte_count), 32'd1);
    check("mid_restart_sum", 32'(checksum),   32'hAB);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
